// File: rtl/morse_pkg.sv
// Shared types, letter codes and the Morse pattern lookup for the character path.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [5:0] CODE_INVALID = 6'd0;
  localparam logic [5:0] CODE_A = 6'd1;
  localparam logic [5:0] CODE_B = 6'd2;
  localparam logic [5:0] CODE_C = 6'd3;
  localparam logic [5:0] CODE_D = 6'd4;
  localparam logic [5:0] CODE_E = 6'd5;
  localparam logic [5:0] CODE_F = 6'd6;
  localparam logic [5:0] CODE_G = 6'd7;
  localparam logic [5:0] CODE_H = 6'd8;
  localparam logic [5:0] CODE_I = 6'd9;
  localparam logic [5:0] CODE_J = 6'd10;
  localparam logic [5:0] CODE_K = 6'd11;
  localparam logic [5:0] CODE_L = 6'd12;
  localparam logic [5:0] CODE_M = 6'd13;
  localparam logic [5:0] CODE_N = 6'd14;
  localparam logic [5:0] CODE_O = 6'd15;
  localparam logic [5:0] CODE_P = 6'd16;
  localparam logic [5:0] CODE_Q = 6'd17;
  localparam logic [5:0] CODE_R = 6'd18;
  localparam logic [5:0] CODE_S = 6'd19;
  localparam logic [5:0] CODE_T = 6'd20;
  localparam logic [5:0] CODE_U = 6'd21;
  localparam logic [5:0] CODE_V = 6'd22;
  localparam logic [5:0] CODE_W = 6'd23;
  localparam logic [5:0] CODE_X = 6'd24;
  localparam logic [5:0] CODE_Y = 6'd25;
  localparam logic [5:0] CODE_Z = 6'd26;

  // bits holds the elements with the first keyed one in bits[len-1]; 1=dash, 0=dot.
  function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [3:0] bits);
    logic [5:0] code;
    code = CODE_INVALID;
    case (len)
      3'd1: code = bits[0] ? CODE_T : CODE_E;
      3'd2: begin
        case (bits[1:0])
          2'b00: code = CODE_I;
          2'b01: code = CODE_A;
          2'b10: code = CODE_N;
          2'b11: code = CODE_M;
        endcase
      end
      3'd3: begin
        case (bits[2:0])
          3'b000: code = CODE_S;
          3'b001: code = CODE_U;
          3'b010: code = CODE_R;
          3'b011: code = CODE_W;
          3'b100: code = CODE_D;
          3'b101: code = CODE_K;
          3'b110: code = CODE_G;
          3'b111: code = CODE_O;
        endcase
      end
      3'd4: begin
        case (bits)
          4'b0000: code = CODE_H;
          4'b0001: code = CODE_V;
          4'b0010: code = CODE_F;
          4'b0100: code = CODE_L;
          4'b0110: code = CODE_P;
          4'b0111: code = CODE_J;
          4'b1000: code = CODE_B;
          4'b1001: code = CODE_X;
          4'b1010: code = CODE_C;
          4'b1011: code = CODE_Y;
          4'b1100: code = CODE_Z;
          4'b1101: code = CODE_Q;
          default: code = CODE_INVALID;
        endcase
      end
      default: code = CODE_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a stability-count debouncer for the Morse key.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_db
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          key_meta;
  logic          key_sync;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Follow key_sync only after it has differed from key_db for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      key_db <= 1'b0;
    end else if (key_sync == key_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      key_db <= key_sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Classifies debounced key presses as dots/dashes, collects up to four elements and
// emits a letter code with a one-cycle strobe after the inter-character gap.
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned DOT_MAX_CYC  = 2_000_000,
  parameter int unsigned CHAR_GAP_CYC = 6_000_000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [5:0] char_code,
  output logic       char_ready,
  output logic       char_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CHAR_GAP_CYC - 1);

  state_t           state;
  logic             key_db;
  logic [CNT_W-1:0] press_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       sym_bits;
  logic [2:0]       sym_len;
  logic [5:0]       code_next;

  key_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .key_db(key_db)
  );

  // Letter for the elements collected so far.
  always_comb begin
    code_next = morse_lookup(sym_len, sym_bits);
  end

  assign busy = (state != IDLE);

  // Keying FSM: times presses and gaps, shifts in elements, registers the emission.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      press_cnt  <= '0;
      gap_cnt    <= '0;
      sym_bits   <= '0;
      sym_len    <= '0;
      char_code  <= CODE_INVALID;
      char_ready <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      char_ready <= 1'b0;
      char_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_db) begin
            state     <= PRESS;
            press_cnt <= CNT_W'(1);
          end
        end
        PRESS: begin
          if (key_db) begin
            if (press_cnt != '1) press_cnt <= press_cnt + 1'b1;
          end else begin
            state    <= GAP;
            gap_cnt  <= CNT_W'(1);
            sym_bits <= {sym_bits[2:0], (press_cnt >= DOT_MAX)};
            // length sticks at 5 so any overlong symbol decodes as invalid
            sym_len  <= (sym_len >= 3'd5) ? 3'd5 : sym_len + 3'd1;
          end
        end
        GAP: begin
          if (key_db) begin
            state     <= PRESS;
            press_cnt <= CNT_W'(1);
          end else if (gap_cnt == GAP_LAST) begin
            state      <= IDLE;
            char_code  <= code_next;
            char_ready <= 1'b1;
            char_err   <= (code_next == CODE_INVALID);
            sym_bits   <= '0;
            sym_len    <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder with shortened timing parameters.
module tb_morse_symbol_decoder;

  logic       clk;
  logic       rst;
  logic       key;
  logic [5:0] char_code;
  logic       char_ready;
  logic       char_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int lat;
  int s0;
  int busy_seen;

  // Release-to-strobe latency: 2 sync flops + 4 debounce cycles + 60 gap cycles.
  localparam int LAT = 66;

  morse_symbol_decoder #(
    .DEBOUNCE_CYC(4),
    .DOT_MAX_CYC (20),
    .CHAR_GAP_CYC(60),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .char_code (char_code),
    .char_ready(char_ready),
    .char_err  (char_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every strobe shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (char_ready === 1'b1) strobes++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key = 1'b1;
    cycles(n);
    key = 1'b0;
  endtask

  // Key a letter; element i of pat (msb-first over n elements) is a dash when 1.
  task automatic send_letter(input int n, input logic [4:0] pat);
    for (int i = n - 1; i >= 0; i--) begin
      press(pat[i] ? 30 : 10);
      if (i > 0) cycles(20);
    end
  endtask

  // Called right after key release; checks latency, code, error flag and strobe width.
  task automatic expect_char(input string tag, input logic [5:0] code, input logic err);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (char_ready === 1'b1) break;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_code"}, char_code, code);
    chk({tag, "_err"}, char_err, err);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, char_ready, 0);
  endtask

  initial begin
    rst = 1'b0;
    key = 1'b0;
    cycles(3);
    chk("rst_code", char_code, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_err", char_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    cycles(3);

    // single dot -> E
    s0 = strobes;
    key = 1'b1;
    cycles(10);
    chk("e_busy_press", busy, 1);
    key = 1'b0;
    expect_char("e", 6'd5, 1'b0);
    chk("e_strobes", strobes - s0, 1);

    // -.-. -> C
    send_letter(4, 5'b01010);
    expect_char("c", 6'd3, 1'b0);

    // press-length boundary
    press(20);
    expect_char("t20", 6'd20, 1'b0);
    press(19);
    expect_char("e19", 6'd5, 1'b0);

    // five dots overflow -> invalid
    send_letter(5, 5'b00000);
    expect_char("five", 6'd0, 1'b1);
    // unassigned 4-element pattern ..--
    send_letter(4, 5'b00011);
    expect_char("uu", 6'd0, 1'b1);
    // --.- -> Q
    send_letter(4, 5'b01101);
    expect_char("q", 6'd17, 1'b0);

    // gap of 59 continues the letter -> I
    s0 = strobes;
    press(10);
    cycles(59);
    press(10);
    expect_char("gap59", 6'd9, 1'b0);
    chk("gap59_strobes", strobes - s0, 1);

    // gap of 60 ends the letter: E then E again
    s0 = strobes;
    press(10);
    cycles(60);
    press(10);
    expect_char("gap60", 6'd5, 1'b0);
    chk("gap60_strobes", strobes - s0, 2);

    // saturated press counter still a dash
    press(300);
    expect_char("sat", 6'd20, 1'b0);

    // glitches of 2 and 3 cycles never reach the FSM
    s0 = strobes;
    busy_seen = 0;
    press(2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    press(3);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    chk("glitch_busy", busy_seen, 0);
    chk("glitch_strobes", strobes - s0, 0);
    chk("glitch_hold", char_code, 20);

    // reset during the gap after two dots discards the symbol
    press(10);
    cycles(20);
    press(10);
    cycles(10);
    chk("gap_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_code", char_code, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", char_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    s0 = strobes;
    cycles(100);
    chk("post_rst_strobes", strobes - s0, 0);
    chk("post_rst_busy", busy, 0);
    press(30);
    expect_char("post_rst_t", 6'd20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
